hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard stall / flush / mul-div freeze controller
//
// Purpose: resolves load-use hazards with a single bubble, flushes IF/ID on a
// taken branch, and freezes the front of the pipe for MULDIV_CYCLES cycles
// while a multi-cycle mul/div executes in EX. Also counts PC-stall cycles.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   IF_ID_rs/rt     source fields of the instruction in ID
//   ID_uses_rt      ID instruction reads rt
//   ID_EX_rt        destination of the instruction in EX
//   ID_EX_MemRead   EX instruction is a load
//   muldiv_start    EX instruction is a mul/div
//   branch_taken    branch/jump resolved taken in EX
//   PC_write        PC update enable
//   IF_ID_write     IF/ID register enable
//   en_reg          ID/EX register enable
//   ID_EX_bubble    zero the control word entering ID/EX
//   IF_ID_flush     clear IF/ID to NOP
//   muldiv_busy     mul/div freeze in progress
//   muldiv_done     one-cycle pulse as the freeze releases
//   stall_cycles    saturating count of cycles with PC_write=0

module hazard_stall_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        ID_uses_rt,
  input  logic [4:0]  ID_EX_rt,
  input  logic        ID_EX_MemRead,
  input  logic        muldiv_start,
  input  logic        branch_taken,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        en_reg,
  output logic        ID_EX_bubble,
  output logic        IF_ID_flush,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  // The start cycle is already one freeze cycle, and MD_BUSY exits on cnt==0,
  // so loading N-2 yields exactly N frozen cycles in total.
  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 2);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;
  logic        lu;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
              ((ID_EX_rt == IF_ID_rs) || (ID_uses_rt && (ID_EX_rt == IF_ID_rt)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    en_reg       = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    muldiv_busy  = 1'b0;
    muldiv_done  = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else if (muldiv_start) begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          en_reg      = 1'b0;
          muldiv_busy = 1'b1;
          state_d     = MD_BUSY;
          cnt_d       = CNT_LOAD;
        end else if (lu) begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
      end
      MD_BUSY: begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        en_reg      = 1'b0;
        muldiv_busy = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      MD_DONE: begin
        // muldiv_start is still high for the op just finished; ignoring it
        // here is what prevents an immediate retrigger.
        muldiv_done = 1'b1;
        state_d     = RUN;
        if (branch_taken) begin
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else if (lu) begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!PC_write && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic        ID_uses_rt;
  logic [4:0]  ID_EX_rt;
  logic        ID_EX_MemRead;
  logic        muldiv_start;
  logic        branch_taken;
  logic        PC_write;
  logic        IF_ID_write;
  logic        en_reg;
  logic        ID_EX_bubble;
  logic        IF_ID_flush;
  logic        muldiv_busy;
  logic        muldiv_done;
  logic [15:0] stall_cycles;

  hazard_stall_ctrl #(.MULDIV_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .IF_ID_rs     (IF_ID_rs),
    .IF_ID_rt     (IF_ID_rt),
    .ID_uses_rt   (ID_uses_rt),
    .ID_EX_rt     (ID_EX_rt),
    .ID_EX_MemRead(ID_EX_MemRead),
    .muldiv_start (muldiv_start),
    .branch_taken (branch_taken),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .en_reg       (en_reg),
    .ID_EX_bubble (ID_EX_bubble),
    .IF_ID_flush  (IF_ID_flush),
    .muldiv_busy  (muldiv_busy),
    .muldiv_done  (muldiv_done),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_write, IF_ID_write, en_reg, ID_EX_bubble, IF_ID_flush, muldiv_busy, muldiv_done}
  logic [6:0] outs;
  assign outs = {PC_write, IF_ID_write, en_reg, ID_EX_bubble, IF_ID_flush, muldiv_busy, muldiv_done};

  localparam logic [6:0] O_DEF   = 7'b1110000;
  localparam logic [6:0] O_LU    = 7'b0011000;
  localparam logic [6:0] O_BR    = 7'b1111100;
  localparam logic [6:0] O_MD    = 7'b0000010;
  localparam logic [6:0] O_DONE  = 7'b1110001;
  localparam logic [6:0] O_DBR   = 7'b1111101;
  localparam logic [6:0] O_DLU   = 7'b0011001;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rt;
    logic [4:0]  ex_rt;
    logic        memread;
    logic        md;
    logic        br;
    logic [6:0]  exp_out;
    logic [15:0] exp_stall;
    logic        exp_busy_next;
  } vec_t;

  vec_t vecs [10];
  int   n_checks;
  int   n_errors;
  logic done_seen;
  logic pc_low_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    IF_ID_rs      = 5'd0;
    IF_ID_rt      = 5'd0;
    ID_uses_rt    = 1'b0;
    ID_EX_rt      = 5'd0;
    ID_EX_MemRead = 1'b0;
    muldiv_start  = 1'b0;
    branch_taken  = 1'b0;
  endtask

  task automatic set_lu();
    ID_EX_MemRead = 1'b1;
    ID_EX_rt      = 5'd8;
    IF_ID_rs      = 5'd8;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    //        rs     rt     use   ex_rt  mr    md    br    out     stall  busy_next
    vecs[0] = '{5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_DEF, 16'd0, 1'b0};
    vecs[1] = '{5'd8, 5'd0, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, O_LU,  16'd1, 1'b0};
    vecs[2] = '{5'd0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, O_DEF, 16'd0, 1'b0};
    vecs[3] = '{5'd3, 5'd9, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, O_DEF, 16'd0, 1'b0};
    vecs[4] = '{5'd3, 5'd9, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, O_LU,  16'd1, 1'b0};
    vecs[5] = '{5'd8, 5'd8, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, O_DEF, 16'd0, 1'b0};
    vecs[6] = '{5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, O_BR,  16'd0, 1'b0};
    vecs[7] = '{5'd0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, O_MD,  16'd1, 1'b1};
    vecs[8] = '{5'd8, 5'd0, 1'b0, 5'd8,  1'b1, 1'b1, 1'b1, O_BR,  16'd0, 1'b0};
    vecs[9] = '{5'd8, 5'd0, 1'b0, 5'd8,  1'b1, 1'b1, 1'b0, O_MD,  16'd1, 1'b1};

    // reset state while rst held
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'(O_DEF));
    check("reset_stall", 32'(stall_cycles), 32'd0);
    rst = 1'b0;

    // single-cycle table vectors, each starting from a fresh reset in RUN
    for (int i = 0; i < 10; i++) begin
      do_reset();
      @(negedge clk);
      IF_ID_rs      = vecs[i].rs;
      IF_ID_rt      = vecs[i].rt;
      ID_uses_rt    = vecs[i].uses_rt;
      ID_EX_rt      = vecs[i].ex_rt;
      ID_EX_MemRead = vecs[i].memread;
      muldiv_start  = vecs[i].md;
      branch_taken  = vecs[i].br;
      #1;
      check($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp_out));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_stall", i), 32'(stall_cycles), 32'(vecs[i].exp_stall));
      clear_inputs();
      #1;
      check($sformatf("vec%0d_busy_next", i), 32'(muldiv_busy), 32'(vecs[i].exp_busy_next));
    end

    // mul/div with start held high: 4 frozen cycles, one done cycle, no retrigger
    do_reset();
    @(negedge clk);
    muldiv_start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("md_hold_c%0d", c), 32'(outs), 32'(O_MD));
      @(negedge clk);
    end
    #1;
    check("md_hold_done", 32'(outs), 32'(O_DONE));
    muldiv_start = 1'b0;
    @(negedge clk);
    #1;
    check("md_hold_after", 32'(outs), 32'(O_DEF));
    check("md_hold_stall", 32'(stall_cycles), 32'd4);

    // MD_BUSY ignores branch/lu; MD_DONE honours branch over lu
    do_reset();
    @(negedge clk);
    muldiv_start = 1'b1;
    @(negedge clk);
    muldiv_start = 1'b0;
    branch_taken = 1'b1;
    set_lu();
    for (int c = 1; c < 4; c++) begin
      #1;
      check($sformatf("md_ignore_c%0d", c), 32'(outs), 32'(O_MD));
      @(negedge clk);
    end
    #1;
    check("md_done_branch", 32'(outs), 32'(O_DBR));
    clear_inputs();
    @(negedge clk);
    #1;
    check("md_done_branch_after", 32'(outs), 32'(O_DEF));
    check("md_done_branch_stall", 32'(stall_cycles), 32'd4);

    // asynchronous reset mid-freeze
    do_reset();
    @(negedge clk);
    muldiv_start = 1'b1;
    @(negedge clk);
    muldiv_start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_outs", 32'(outs), 32'(O_DEF));
    check("midrst_stall", 32'(stall_cycles), 32'd0);
    rst = 1'b0;
    done_seen   = 1'b0;
    pc_low_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (muldiv_done) done_seen = 1'b1;
      if (!PC_write) pc_low_seen = 1'b1;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    check("midrst_no_stall", 32'(pc_low_seen), 32'd0);
    check("midrst_stall_after", 32'(stall_cycles), 32'd0);

    // saturation: back-to-back mul/div with a load-use stalling each done cycle
    do_reset();
    @(negedge clk);
    muldiv_start = 1'b1;
    set_lu();
    repeat (4) @(negedge clk);
    #1;
    check("sat_done_lu", 32'(outs), 32'(O_DLU));
    repeat (96) @(posedge clk);
    #1;
    check("sat_count_100", 32'(stall_cycles), 32'd100);
    repeat (69900) @(posedge clk);
    #1;
    check("sat_ffff", 32'(stall_cycles), 32'hFFFF);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
